// File: rtl/genetico_pkg.sv
// Shared constants and types for the evolvable-circuit datapath and its
// serial chromosome loader.
package genetico_pkg;
  localparam int N_LE       = 27;
  localparam int LE_W       = 15;
  localparam int N_OUT      = 4;
  localparam int SEL_W      = 6;
  localparam int N_IN       = 8;
  localparam int N_ALL      = 35;
  localparam int FRAME_BITS = N_LE * LE_W + N_OUT * SEL_W;

  typedef logic [LE_W-1:0]  le_conf_t;
  typedef logic [SEL_W-1:0] out_sel_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } ld_state_t;
endpackage

// File: rtl/chrom_loader_if.sv
// Bit-serial valid/ready link carrying chromosome frames into chrom_loader.
interface chrom_loader_if;
  logic ser_valid;
  logic ser_data;
  logic ser_sof;
  logic ser_ready;

  modport master (output ser_valid, output ser_data, output ser_sof, input ser_ready);
  modport slave  (input ser_valid, input ser_data, input ser_sof, output ser_ready);
endinterface

// File: rtl/chrom_loader.sv
// Serial chromosome loader: shifts a frame MSB-first into a shadow register and
// commits it atomically to the active configuration. Optional: CHROM_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a bit with sof; bits without sof are dropped
// LOAD   | shifting frame bits into the shadow; sof restarts the frame
// COMMIT | one cycle, ready low; shadow copied to the active configuration
module chrom_loader
  import genetico_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  chrom_loader_if.slave         ser,
  output le_conf_t [N_LE-1:0]   conf_les,
  output out_sel_t [N_OUT-1:0]  conf_outs,
  output logic                  conf_valid,
  output logic                  commit_pulse,
  output logic                  busy
`ifdef CHROM_PARITY_EN
  ,
  output logic                  frame_err
`endif
);

`ifdef CHROM_PARITY_EN
  localparam int FRAME_LEN = FRAME_BITS + 1;
`else
  localparam int FRAME_LEN = FRAME_BITS;
`endif
  localparam logic [8:0] PRE_LAST   = 9'(FRAME_LEN - 1);
  localparam logic [8:0] SHADOW_LEN = 9'(FRAME_BITS);

  ld_state_t             state, state_nxt;
  logic [8:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shadow;
  logic                  ready_q;
  logic                  xfer, start, last_bit, commit_ok;

  assign ser.ser_ready = ready_q;
  assign busy          = (state != IDLE);
  assign xfer          = ser.ser_valid & ready_q;
  assign start         = xfer & ser.ser_sof;
  assign last_bit      = xfer & ~ser.ser_sof & (bit_cnt == PRE_LAST);

`ifdef CHROM_PARITY_EN
  logic par;
  assign commit_ok = ~par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= (state == COMMIT) & par;
      if (start)
        par <= ser.ser_data;
      else if (xfer && state == LOAD)
        par <= par ^ ser.ser_data;
    end
  end
`else
  assign commit_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (last_bit) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ready is a registered decode of the next state so it stays low in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != COMMIT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt      <= '0;
      shadow       <= '0;
      conf_les     <= '0;
      conf_outs    <= '0;
      conf_valid   <= 1'b0;
      commit_pulse <= 1'b0;
    end else begin
      commit_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shadow  <= {{(FRAME_BITS-1){1'b0}}, ser.ser_data};
            bit_cnt <= 9'd1;
          end
        end
        LOAD: begin
          if (start) begin
            shadow  <= {{(FRAME_BITS-1){1'b0}}, ser.ser_data};
            bit_cnt <= 9'd1;
          end else if (xfer) begin
            bit_cnt <= bit_cnt + 9'd1;
            // a trailing parity bit is counted but never enters the shadow
            if (bit_cnt < SHADOW_LEN)
              shadow <= {shadow[FRAME_BITS-2:0], ser.ser_data};
          end
        end
        COMMIT: begin
          bit_cnt <= '0;
          if (commit_ok) begin
            {conf_outs, conf_les} <= shadow;
            conf_valid            <= 1'b1;
            commit_pulse          <= 1'b1;
          end
        end
        default: bit_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_chrom_loader.sv
// Directed bench for chrom_loader: frames are pushed to a scoreboard as they
// are driven and compared against the active configuration at commit.
module tb_chrom_loader;
  import genetico_pkg::*;

  typedef logic [FRAME_BITS-1:0] fv_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chrom_loader_if sif ();
  le_conf_t [N_LE-1:0]  conf_les;
  out_sel_t [N_OUT-1:0] conf_outs;
  logic conf_valid, commit_pulse, busy;
`ifdef CHROM_PARITY_EN
  logic frame_err;
`endif

  chrom_loader dut (
    .clk          (clk),
    .rst          (rst),
    .ser          (sif),
    .conf_les     (conf_les),
    .conf_outs    (conf_outs),
    .conf_valid   (conf_valid),
    .commit_pulse (commit_pulse),
    .busy         (busy)
`ifdef CHROM_PARITY_EN
    ,
    .frame_err    (frame_err)
`endif
  );

  int  errors = 0;
  int  checks = 0;
  int  pulse_cnt = 0;
  int  nrdy_cnt = 0;
  fv_t exp_q[$];

  always @(negedge clk) begin
    if (commit_pulse) pulse_cnt++;
    if (!sif.ser_ready && !rst) nrdy_cnt++;
  end

  task automatic chk(input string tag, input fv_t obs, input fv_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fv_t mk(input int mul, input int add, input int oadd);
    fv_t f;
    f = '0;
    for (int i = 0; i < N_LE; i++) f[i*LE_W +: LE_W] = LE_W'(mul * i + add);
    for (int j = 0; j < N_OUT; j++) f[N_LE*LE_W + j*SEL_W +: SEL_W] = SEL_W'(oadd + j);
    return f;
  endfunction

  function automatic fv_t rnd_frame();
    fv_t f;
    for (int b = 0; b < FRAME_BITS; b++) f[b] = 1'($urandom);
    return f;
  endfunction

  // returns just after the edge at which the bit was accepted
  task automatic drive_bit(input logic d, input logic sof, input bit gapped);
    bit done;
    int tries;
    logic rdy;
    done  = 0;
    tries = 0;
    while (!done) begin
      @(negedge clk);
      if (gapped && $urandom_range(1, 0) == 0) begin
        sif.ser_valid = 1'b0;
        sif.ser_data  = 1'($urandom);
        sif.ser_sof   = 1'($urandom);
      end else begin
        sif.ser_valid = 1'b1;
        sif.ser_data  = d;
        sif.ser_sof   = sof;
      end
      rdy = sif.ser_ready;
      @(posedge clk);
      if (sif.ser_valid && rdy) done = 1;
      tries++;
      if (!done && tries > 60) begin
        chk("accept_timeout", fv_t'(0), fv_t'(1));
        done = 1;
      end
    end
  endtask

  task automatic send_bits(input fv_t f, input int n, input bit gapped, input bit bad_par);
    for (int k = 0; k < n; k++) drive_bit(f[FRAME_BITS-1-k], k == 0, gapped);
`ifdef CHROM_PARITY_EN
    if (n == FRAME_BITS) drive_bit((^f) ^ bad_par, 1'b0, gapped);
`else
    if (bad_par) chk("bad_par_unsupported", fv_t'(0), fv_t'(1));
`endif
  endtask

  task automatic idle_inputs();
    sif.ser_valid = 1'b0;
    sif.ser_data  = 1'b0;
    sif.ser_sof   = 1'b0;
  endtask

  // called right after the last bit's accepting edge
  task automatic expect_commit(input string tag);
    fv_t exp;
    @(negedge clk);
    idle_inputs();
    chk({tag, "_ready_low"}, fv_t'(sif.ser_ready), fv_t'(0));
    chk({tag, "_busy"}, fv_t'(busy), fv_t'(1));
    chk({tag, "_pulse_early"}, fv_t'(commit_pulse), fv_t'(0));
    @(negedge clk);
    chk({tag, "_pulse"}, fv_t'(commit_pulse), fv_t'(1));
    chk({tag, "_valid"}, fv_t'(conf_valid), fv_t'(1));
    chk({tag, "_ready_back"}, fv_t'(sif.ser_ready), fv_t'(1));
    if (exp_q.size() == 0) chk({tag, "_sb_empty"}, fv_t'(exp_q.size()), fv_t'(1));
    else begin
      exp = exp_q.pop_front();
      chk({tag, "_conf"}, fv_t'({conf_outs, conf_les}), exp);
    end
    @(negedge clk);
    chk({tag, "_pulse_drop"}, fv_t'(commit_pulse), fv_t'(0));
  endtask

  initial begin
    fv_t fa, fb, fc, fx;
    int  p0, n0;
    fa = mk(1, 0, 8);
    fb = mk(3, 100, 40);
    fc = rnd_frame();
    fx = rnd_frame();

    rst = 1'b1;
    idle_inputs();
    #2;
    chk("rst_conf", fv_t'({conf_outs, conf_les}), fv_t'(0));
    chk("rst_valid", fv_t'(conf_valid), fv_t'(0));
    chk("rst_pulse", fv_t'(commit_pulse), fv_t'(0));
    chk("rst_busy", fv_t'(busy), fv_t'(0));
    chk("rst_ready", fv_t'(sif.ser_ready), fv_t'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", fv_t'(sif.ser_ready), fv_t'(1));
    chk("rel_valid", fv_t'(conf_valid), fv_t'(0));

    // stray bits without sof
    p0 = pulse_cnt;
    for (int k = 0; k < 10; k++) drive_bit(1'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk("stray_busy", fv_t'(busy), fv_t'(0));
    chk("stray_pulses", fv_t'(pulse_cnt - p0), fv_t'(0));

    // full load, valid held high
    p0 = pulse_cnt;
    n0 = nrdy_cnt;
    exp_q.push_back(fa);
    send_bits(fa, FRAME_BITS, 1'b0, 1'b0);
    expect_commit("full");
    chk("full_one_pulse", fv_t'(pulse_cnt - p0), fv_t'(1));
    chk("full_one_nrdy", fv_t'(nrdy_cnt - n0), fv_t'(1));
    chk("full_le5", fv_t'(conf_les[5]), fv_t'(5));
    chk("full_le26", fv_t'(conf_les[26]), fv_t'(26));
    chk("full_out3", fv_t'(conf_outs[3]), fv_t'(11));

    // gapped stream with garbage while invalid
    p0 = pulse_cnt;
    exp_q.push_back(fa);
    send_bits(fa, FRAME_BITS, 1'b1, 1'b0);
    expect_commit("gap");
    chk("gap_one_pulse", fv_t'(pulse_cnt - p0), fv_t'(1));

    // restart: 200 bits of an aborted frame, then full frame B
    p0 = pulse_cnt;
    send_bits(fx, 200, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    chk("restart_hold", fv_t'({conf_outs, conf_les}), fa);
    chk("restart_busy", fv_t'(busy), fv_t'(1));
    chk("restart_no_pulse", fv_t'(pulse_cnt - p0), fv_t'(0));
    exp_q.push_back(fb);
    send_bits(fb, FRAME_BITS, 1'b0, 1'b0);
    expect_commit("restart");
    chk("restart_one_pulse", fv_t'(pulse_cnt - p0), fv_t'(1));
    chk("restart_out0", fv_t'(conf_outs[0]), fv_t'(40));

    // reset mid-frame, asserted between edges
    send_bits(fc, 300, 1'b0, 1'b0);
    @(negedge clk);
    idle_inputs();
    #2 rst = 1'b1;
    #1;
    chk("midrst_conf", fv_t'({conf_outs, conf_les}), fv_t'(0));
    chk("midrst_valid", fv_t'(conf_valid), fv_t'(0));
    chk("midrst_ready", fv_t'(sif.ser_ready), fv_t'(0));
    chk("midrst_busy", fv_t'(busy), fv_t'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rel_ready", fv_t'(sif.ser_ready), fv_t'(1));
    exp_q.push_back(fc);
    send_bits(fc, FRAME_BITS, 1'b0, 1'b0);
    expect_commit("after_rst");

`ifdef CHROM_PARITY_EN
    p0 = pulse_cnt;
    send_bits(fa, FRAME_BITS, 1'b0, 1'b1);
    @(negedge clk);
    idle_inputs();
    chk("par_err_early", fv_t'(frame_err), fv_t'(0));
    @(negedge clk);
    chk("par_err", fv_t'(frame_err), fv_t'(1));
    chk("par_no_pulse", fv_t'(commit_pulse), fv_t'(0));
    chk("par_hold", fv_t'({conf_outs, conf_les}), fc);
    chk("par_valid", fv_t'(conf_valid), fv_t'(1));
    @(negedge clk);
    chk("par_err_drop", fv_t'(frame_err), fv_t'(0));
    chk("par_pulses", fv_t'(pulse_cnt - p0), fv_t'(0));
`endif

    chk("sb_drained", fv_t'(exp_q.size()), fv_t'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/chrom_loader.md
# chrom_loader

Serial chromosome loader for the evolvable-circuit datapath. It receives a bit-serial chromosome frame over a valid/ready handshake and assembles it into a shadow register. On frame completion it commits the frame atomically to the `conf_les` / `conf_outs` configuration that drives `genetico`. The evaluated circuit therefore never sees a partially loaded chromosome.

## Interface
Parameters (values fixed by `genetico_pkg`, not overridable):
- `N_LE`, 27, number of logic elements
- `LE_W`, 15, bits per element config (func[14:12], ins[11:0])
- `N_OUT`, 4, circuit outputs
- `SEL_W`, 6, output selector width
- `FRAME_BITS`, 429, N_LE*LE_W + N_OUT*SEL_W

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset; asynchronous, active-high
- `ser_valid`  in  1  serial bit valid
- `ser_data`  in  1  serial bit
- `ser_sof`  in  1  start of frame; qualifies the bit transferred with it as frame bit 0
- `ser_ready`  out  1  loader accepts a bit this cycle
- `conf_les`  out  [26:0][14:0]  active element configuration
- `conf_outs`  out  [3:0][5:0]  active output selectors
- `conf_valid`  out  1  at least one frame committed since reset
- `commit_pulse`  out  1  one-cycle strobe, coincident with newly committed outputs
- `busy`  out  1  frame in progress (state LOAD or COMMIT)

## Operation
- Transfer: `ser_valid & ser_ready` at a rising edge. Inputs are ignored when there is no transfer.
- Frame vector F[428:0] = {conf_outs[3..0], conf_les[26..0]}, packed. `conf_outs[3][5]` is F[428]; `conf_les[0][0]` is F[0].
- Bits are sent MSB first (F[428] first). The shadow register shifts left, and the new bit enters the LSB.
- A 9-bit counter `bit_cnt` counts accepted bits.
- States:
  - IDLE: `ser_ready`=1. A transfer with `ser_sof`=1 loads that bit and sets `bit_cnt`=1, then goes to LOAD. A transfer without sof is dropped.
  - LOAD: `ser_ready`=1. Each transfer shifts in a bit and increments `bit_cnt`. A transfer with sof restarts the frame: shadow takes the new bit, `bit_cnt`=1, state stays LOAD. When the accepted bit makes `bit_cnt` = frame length, go to COMMIT.
  - COMMIT: `ser_ready`=0, one cycle. Active registers are loaded from shadow, `commit_pulse`=1 and `conf_valid`=1, then go to IDLE.
- Active outputs change only in COMMIT. A restarted or aborted frame leaves the previous configuration intact.
- Selector values are passed through unchecked. Values above 34 are `genetico`'s concern.
- Reset values: all `conf_les` and `conf_outs` bits 0, `conf_valid` 0, `commit_pulse` 0, `busy` 0, state IDLE, `bit_cnt` 0, shadow 0. `ser_ready` is 0 while `rst` is high.
- Reset mid-frame discards the frame and clears the active configuration.

## Timing
- Last frame bit accepted at edge k: state is COMMIT during cycle k..k+1, and `ser_ready` is 0 in that cycle.
- At edge k+1 the new `conf_*` values, `commit_pulse`=1 and `conf_valid`=1 appear together. `commit_pulse` drops at k+2.
- Minimum frame period: frame length + 1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `ser_ready` is a function of state only.

## Configuration
- `CHROM_PARITY_EN` defined:
  - Frame length is 430. Bit 429 (sent last) is even parity, so the XOR of all 430 bits must be 0.
  - A running parity flop is cleared on sof.
  - In COMMIT, a mismatch suppresses the register load and `commit_pulse`. Instead an extra output `frame_err` (out, 1) pulses for that cycle. `conf_valid` is unchanged.
  - `frame_err` resets to 0.
- `CHROM_PARITY_EN` not defined: frame length is 429, and there is no parity logic and no `frame_err` port.

## Structure
- `genetico_pkg` holds:
  - constants N_LE, LE_W, N_OUT, SEL_W, N_IN=8, N_ALL=35, FRAME_BITS
  - typedefs `le_conf_t` (logic [14:0]) and `out_sel_t` (logic [5:0])
  - the loader state enum {IDLE, LOAD, COMMIT}
- Single module with no sub-modules. The shadow is a plain shift register; counter, FSM and active registers are in the same file.

## Test plan
- Reset: assert `rst` mid-cycle. All outputs are 0 asynchronously, and `ser_ready` is 0. After release, `ser_ready`=1 and `conf_valid`=0.
- Full load: stream a frame with `conf_les[i]`=i and `conf_outs[j]`=8+j, `ser_valid` held high. Exactly one `commit_pulse` occurs, 1 cycle after the last bit. Outputs match, `conf_valid`=1, and `ser_ready`=0 for exactly that cycle.
- Gapped stream: same frame with `ser_valid` randomly low 50% of cycles, plus garbage `ser_data` while invalid. The result is identical and the commit follows the 429th accepted bit.
- Restart and stray bits:
  - 10 bits without sof in IDLE are dropped, with no state change.
  - A second sof after 200 bits of frame A, followed by complete frame B, commits B only. The frame-A (prior) config holds until B commits.
- Reset mid-frame: after frame A is committed, load 300 bits of frame B, then pulse `rst`. The outputs are 0 and `conf_valid`=0. A following full frame C commits normally.
- With `CHROM_PARITY_EN`:
  - A correct-parity frame commits.
  - A frame with one flipped bit gives `frame_err` pulsed, `commit_pulse`=0, and the previous config retained.
